icache_fetch: RTL and testbench

ICACHE_FETCH -- requirements
Module: icache_fetch

---
 rtl/icache_fetch.sv | 182 ++++++++++++++++++
 tb/tb_icache_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - instruction fetch stage with set-associative I-cache and line refill FSM
module icache_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  PCSrcE,
  input  logic                  JALRinstrE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_rdata,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  validF,
  output logic                  missStallF
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int WIDX      = (WORD_BITS == 0) ? 1 : WORD_BITS;
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_LO    = 2 + WORD_BITS + SET_BITS;
  localparam int TAG_W     = DATA_WIDTH - TAG_LO;
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {LOOKUP, REQ, BURST, FILL} state_t;

  state_t                r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_line_addr;
  logic [WAY_BITS-1:0]   r_victim;
  logic [SET_BITS-1:0]   r_fill_set;
  logic [TAG_W-1:0]      r_fill_tag;
  logic [WIDX-1:0]       r_beat;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_pend_target;

  // Data and tags are never reset; only the valid bits decide what can hit.
  logic [31:0]           r_data  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAY_BITS-1:0]   r_rr    [SETS];

  logic [SET_BITS-1:0]   w_set;
  logic [WIDX-1:0]       w_word;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [WAY_BITS-1:0]   w_hit_way;
  logic                  w_free;
  logic [WAY_BITS-1:0]   w_victim;
  logic [DATA_WIDTH-1:0] w_line_base;
  logic [DATA_WIDTH-1:0] w_redir_target;
  logic                  w_redirect;
  logic                  w_last_beat;

  assign w_set          = r_pc[2+WORD_BITS +: SET_BITS];
  assign w_word         = (LINE_WORDS > 1) ? r_pc[2 +: WIDX] : '0;
  assign w_tag          = r_pc[DATA_WIDTH-1 -: TAG_W];
  assign w_line_base    = r_pc & ~DATA_WIDTH'((1 << (2 + WORD_BITS)) - 1);
  assign w_redir_target = JALRinstrE ? (ALUResultE & ~DATA_WIDTH'(1)) : PCTargetE;
  assign w_redirect     = enable & PCSrcE;
  assign w_last_beat    = (r_beat == WIDX'(LINE_WORDS - 1));

  // Tag compare across the ways of the indexed set, plus victim choice for a miss.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_free    = 1'b0;
    w_victim  = r_rr[w_set];
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_set][w] && (r_tag[w][w_set] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (!w_free && !r_valid[w_set][w]) begin
        w_free   = 1'b1;
        w_victim = WAY_BITS'(w);
      end
    end
  end

  // Next-state logic and the fetch/refill handshake outputs.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    validF       = 1'b0;
    case (r_state)
      LOOKUP: begin
        validF = w_hit & ~reset;
        if (!w_hit) w_next_state = REQ;
      end
      REQ: begin
        mem_req = ~reset;
        if (mem_ready) w_next_state = BURST;
      end
      BURST: begin
        if (mem_valid && w_last_beat) w_next_state = FILL;
      end
      FILL: begin
        w_next_state = LOOKUP;
      end
      default: w_next_state = LOOKUP;
    endcase
  end

  assign missStallF = ~validF;
  assign mem_addr   = r_line_addr;
  assign instrF     = DATA_WIDTH'(r_data[w_hit_way][w_set][w_word]);
  assign PCF        = r_pc;
  assign PCPlus4F   = r_pc + DATA_WIDTH'(4);

  // State register, refill bookkeeping, valid/replacement state and PC update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LOOKUP;
      r_pc          <= '0;
      r_beat        <= '0;
      r_pend        <= 1'b0;
      r_pend_target <= '0;
      r_line_addr   <= '0;
      r_victim      <= '0;
      r_fill_set    <= '0;
      r_fill_tag    <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_next_state;
      case (r_state)
        LOOKUP: begin
          if (!w_hit) begin
            r_line_addr              <= w_line_base;
            r_victim                 <= w_victim;
            r_fill_set               <= w_set;
            r_fill_tag               <= w_tag;
            r_beat                   <= '0;
            r_valid[w_set][w_victim] <= 1'b0;
          end
        end
        BURST: begin
          if (mem_valid) r_beat <= r_beat + 1'b1;
        end
        FILL: begin
          r_valid[r_fill_set][r_victim] <= 1'b1;
          if (WAYS > 1) r_rr[r_fill_set] <= r_rr[r_fill_set] + 1'b1;
        end
        default: ;
      endcase

      // A redirect seen during a stall is parked until the fetch completes.
      if (!missStallF) begin
        if (enable) begin
          if (w_redirect)  r_pc <= w_redir_target;
          else if (r_pend) r_pc <= r_pend_target;
          else             r_pc <= PCPlus4F;
          r_pend <= 1'b0;
        end
      end else if (w_redirect) begin
        r_pend        <= 1'b1;
        r_pend_target <= w_redir_target;
      end
    end
  end

  // Line data and tag storage written by the refill burst.
  always_ff @(posedge clk) begin
    if (!reset && r_state == BURST && mem_valid)
      r_data[r_victim][r_fill_set][r_beat] <= mem_rdata;
    if (!reset && r_state == FILL)
      r_tag[r_victim][r_fill_set] <= r_fill_tag;
  end

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - scoreboard bench for icache_fetch
module tb_icache_fetch;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        PCSrcE;
  logic        JALRinstrE;
  logic [31:0] ALUResultE;
  logic [31:0] PCTargetE;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;
  logic        missStallF;

  always #5 clk = ~clk;

  icache_fetch #(
    .DATA_WIDTH(32), .WAYS(2), .SETS(16), .LINE_WORDS(LW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .PCSrcE(PCSrcE), .JALRinstrE(JALRinstrE),
    .ALUResultE(ALUResultE), .PCTargetE(PCTargetE),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF), .missStallF(missStallF)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return {w[15:0] ^ 16'hC3A5, w[31:16] ^ w[15:0]};
  endfunction

  // Memory responder: ready in the same cycle it sees a request, LW beats back-to-back after.
  int          beats_left = 0;
  int          beat_idx   = 0;
  bit          hs_flag    = 1'b0;
  logic [31:0] hs_addr    = 32'h0;
  logic [31:0] burst_base = 32'h0;
  always @(negedge clk) begin
    if (hs_flag) begin
      beats_left = LW;
      beat_idx   = 0;
      burst_base = hs_addr;
    end
    if (beats_left > 0) begin
      mem_valid = 1'b1;
      mem_rdata = mem_word(burst_base + 32'(4 * beat_idx));
      beat_idx++;
      beats_left--;
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
    end
    mem_ready = mem_req;
    hs_flag   = mem_req && mem_ready && !reset;
    hs_addr   = mem_addr;
  end

  // Scoreboard: every accepted fetch pops the next expected PC.
  logic [31:0] sb_exp;
  always @(negedge clk) begin
    if (!reset && validF && enable) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_fetch", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_exp = sb_q.pop_front();
        check("fetch_pc", PCF, sb_exp);
        check("fetch_instr", instrF, mem_word(sb_exp));
        check("fetch_pc4", PCPlus4F, sb_exp + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int cyc, output logic [31:0] req_addr);
    cyc      = 0;
    req_addr = 32'hFFFF_FFFF;
    while (!validF && cyc < 60) begin
      if (mem_req) req_addr = mem_addr;
      tick();
      cyc++;
    end
    check(tag, 32'(validF), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 30) begin
      tick();
      n++;
    end
    check(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Redirect from a hit cycle: the current fetch is delivered, PC lands on the target next edge.
  task automatic jump(input logic [31:0] target, input logic jalr, input logic [31:0] alu,
                      input logic [31:0] exp_pc, input logic exp_hit);
    int          c;
    logic [31:0] a;
    wait_valid("jump_wait_valid", c, a);
    sb_q.push_back(model_pc);
    enable     = 1'b1;
    PCSrcE     = 1'b1;
    JALRinstrE = jalr;
    ALUResultE = alu;
    PCTargetE  = target;
    tick();
    enable     = 1'b0;
    PCSrcE     = 1'b0;
    JALRinstrE = 1'b0;
    model_pc   = exp_pc;
    check("jump_pc", PCF, exp_pc);
    check("jump_hit", 32'(validF), 32'(exp_hit));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [31:0] addr;
    reset = 1'b1; enable = 1'b0; PCSrcE = 1'b0; JALRinstrE = 1'b0;
    ALUResultE = 32'h0; PCTargetE = 32'h0;
    tick();
    tick();
    check("rst_pc", PCF, 32'h0);
    check("rst_validF", 32'(validF), 32'd0);
    check("rst_missStall", 32'(missStallF), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);

    // Cold start: first hit 7 cycles after release, then the rest of the line back-to-back.
    reset  = 1'b0;
    enable = 1'b1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h4);
    sb_q.push_back(32'h8); sb_q.push_back(32'hC);
    wait_valid("cold_valid", cyc, addr);
    check("cold_latency", 32'(cyc), 32'd7);
    check("cold_mem_addr", addr, 32'h0);
    drain("cold_drain");
    enable   = 1'b0;
    model_pc = 32'h10;
    check("seq_pc", PCF, 32'h10);

    // Set-0 conflict: 0x200 evicts 0x000, 0x100 survives.
    jump(32'h100, 1'b0, 32'h0, 32'h100, 1'b0);
    jump(32'h200, 1'b0, 32'h0, 32'h200, 1'b0);
    jump(32'h100, 1'b0, 32'h0, 32'h100, 1'b1);
    jump(32'h000, 1'b0, 32'h0, 32'h000, 1'b0);

    // JALR target with bit 0 cleared, then a redirect parked during the burst.
    jump(32'h44, 1'b1, 32'h83, 32'h82, 1'b0);
    wait_req("jalr_req");
    check("jalr_mem_addr", mem_addr, 32'h80);
    tick();
    tick();
    tick();
    sb_q.push_back(32'h82);
    enable    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h40;
    tick();
    PCSrcE    = 1'b0;
    check("burst_pc_held", PCF, 32'h82);
    check("burst_stalled", 32'(missStallF), 32'd1);
    cyc = 0;
    while (PCF != 32'h40 && cyc < 30) begin
      tick();
      cyc++;
    end
    enable   = 1'b0;
    model_pc = 32'h40;
    check("pending_redirect_pc", PCF, 32'h40);

    // Pending flag must be gone: a plain advance goes to +4.
    wait_valid("step_valid", cyc, addr);
    sb_q.push_back(32'h40);
    enable = 1'b1;
    tick();
    enable   = 1'b0;
    model_pc = 32'h44;
    check("pending_cleared_pc", PCF, 32'h44);

    // Held by enable=0 on a hit.
    for (int i = 0; i < 3; i++) begin
      check("hold_pc", PCF, 32'h44);
      check("hold_valid", 32'(validF), 32'd1);
      check("hold_instr", instrF, mem_word(32'h44));
      tick();
    end

    // PC+4 wraps at the top of the address space.
    jump(32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0);
    check("wrap_pc4", PCPlus4F, 32'h0);

    // Reset on beat 2: burst abandoned, stray beats ignored, fresh refill of line 0.
    wait_req("wrap_req");
    check("wrap_mem_addr", mem_addr, 32'hFFFF_FFF0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_validF", 32'(validF), 32'd0);
    check("midrst_missStall", 32'(missStallF), 32'd1);
    tick();
    reset = 1'b0;
    model_pc = 32'h0;
    check("midrst_pc", PCF, 32'h0);
    check("midrst_line0_invalid", 32'(validF), 32'd0);
    wait_valid("midrst_valid", cyc, addr);
    check("midrst_latency", 32'(cyc), 32'd7);
    check("midrst_mem_addr", addr, 32'h0);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    enable = 1'b1;
    drain("final_drain");
    enable = 1'b0;
    check("final_pc", PCF, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
